icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised, set-associative, multi-word-block instruction cache; successor to the direct-mapped 1-word icache.
//  Sits between the datapath fetch port (datapath_cache_if.icache) and the memory controller (cache_control_if.icache).
//  Adds WAYS-way associativity with per-set LRU replacement, multi-word block fills, a latched miss address and a hit counter.
// PARAMETERS
//  SETS           8   number of sets, power of two >= 2
//  WAYS           2   associativity, power of two, 1..4
//  WORDS_PER_BLK  2   32-bit words per block, power of two, 1..8
//  CPUID          0   index into ccif per-CPU arrays
// PORTS
//  CLK              in   1   clock
//  nRST             in   1   reset, asynchronous, active-low
//  dcif.imemREN     in   1   fetch request
//  dcif.imemaddr    in   32  fetch byte address; bits[1:0] ignored
//  dcif.ihit        out  1   imemload valid this cycle
//  dcif.imemload    out  32  fetched instruction
//  ccif.iREN[CPUID]   out 1  memory read request
//  ccif.iaddr[CPUID]  out 32 word-aligned memory read address
//  ccif.iwait[CPUID]  in  1  high = memory not ready
//  ccif.iload[CPUID]  in  32 memory read data, valid when iwait low
//  hit_count        out  32  number of fetch requests serviced as hits
// BEHAVIOUR
//  Address split: [1:0] byte, next BOFF_W=log2(WORDS_PER_BLK) blkoff, next IDX_W=log2(SETS) idx, remaining bits tag.
//  Reset: all valid=0, all LRU=0, state IDLE, hit_count=0. Outputs: ihit=0, iREN=0, iaddr=0, imemload=0. Data/tag arrays are not reset.
//  Hit: combinational in IDLE, zero-cycle latency. ihit=imemREN & valid & tag match in any way of set idx.
//   imemload = data[idx][hit_way][blkoff]; otherwise imemload=0.
//   At most one way matches (fill never duplicates a tag); with WAYS=1, LRU is constant.
//  LRU: per set, a WAYS-entry age vector. Each hit and each fill completion makes the touched way MRU.
//   Victim = lowest-numbered invalid way, otherwise the LRU way.
//  hit_count: +1 on each clock edge with ihit=1 in IDLE. Wraps modulo 2^32.
//   A stalled hit held for N cycles counts N; the datapath advances on ihit.
//  FSM states:
//   IDLE: if imemREN & !hit -> FILL.
//    On entry, latch tag/idx into miss_addr, latch victim way, set wcnt=0.
//   FILL: iREN=1, iaddr={miss_tag, miss_idx, wcnt, 2'b00}; ihit=0.
//    On a cycle with iwait=0: write iload into data[miss_idx][victim][wcnt], wcnt+=1.
//    Victim valid is cleared on the first word so a partially filled block can never hit.
//    When wcnt==WORDS_PER_BLK-1 and iwait=0: write tag, set valid=1, update LRU -> IDLE.
//    The request is re-evaluated next cycle and hits.
//  Boundaries:
//   imemaddr or imemREN changes mid-FILL: ignored; the fill completes with the latched address.
//   iwait held high indefinitely: FILL holds with no timeout and iaddr stable.
//   WORDS_PER_BLK=1: FILL lasts one accepted transfer.
//   nRST asserted mid-FILL: immediate return to IDLE, all valid cleared, partial block discarded.
//   imemREN=0 in IDLE: no state change, no LRU update, no count.
//  iaddr in IDLE = 0 (not driven from imemaddr) so memory traffic occurs only in FILL.
// STRUCTURE
//  cpu_types_pkg additions: icache_state_t enum {IDLE, FILL}; ICACHE_WAYS_MAX=4; ICACHE_WPB_MAX=8.
//  Widths are derived locally from parameters with $clog2.
//  One sub-module: icache_lru #(SETS, WAYS).
//   Inputs: set index, touch, touched way, and per-way valid for that set.
//   Output: victim way.
//   Holds the age vectors and resets them asynchronously.
//  Main module: tag/valid/data arrays, hit compare, FSM, miss latches, wcnt, hit_count.
// TESTING
//  1. Cold miss, SETS=8/WAYS=2/WPB=2, iwait=0: fetch 0x0000_0040.
//     Expect FILL with iaddr 0x40 then 0x44, 2 cycles, then ihit with imemload=mem[0x40]; fetch 0x44 hits at once.
//  2. Associativity: fill 0x040, 0x240 and 0x440 (same idx, three tags), touching 0x040 between fills.
//     0x240 must be evicted: 0x040 hits and 0x240 misses.
//  3. iwait stalls: randomised iwait during a fill.
//     iaddr and wcnt hold while iwait=1; the block equals memory; no ihit during FILL.
//  4. Address changes to 0x100 mid-fill of 0x040: the fill completes for 0x040 and 0x100 then misses.
//  5. nRST pulsed mid-FILL: iREN=0 asynchronously; afterwards every prior address misses; hit_count=0.
//  6. hit_count: 10 consecutive hit cycles after a fill -> hit_count=10; misses do not increment it.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared types and limits for the set-associative instruction cache.
//   icache_state_t : controller state encoding
//   ICACHE_*_MAX   : largest supported associativity / block size
//   min1_clog2     : index width that never collapses to zero bits
package icache_assoc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    localparam int ICACHE_WAYS_MAX = 4;
    localparam int ICACHE_WPB_MAX  = 8;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_lru.sv
// Per-set LRU tracker for the instruction cache.
//   clk_i, rst_ni : clock, async active-low reset (all ages cleared)
//   set_i         : set being looked up / touched
//   touch_i       : make way_i the most recently used way of set_i
//   way_i         : way being touched
//   valid_i       : per-way valid bits of set_i
//   victim_o      : lowest invalid way, else the least recently used way
module icache_assoc_lru
    import icache_assoc_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [$clog2(SETS)-1:0]      set_i,
    input  logic                         touch_i,
    input  logic [min1_clog2(WAYS)-1:0]  way_i,
    input  logic [WAYS-1:0]              valid_i,
    output logic [min1_clog2(WAYS)-1:0]  victim_o
);

    localparam int WAY_W = min1_clog2(WAYS);
    localparam int AGE_W = min1_clog2(WAYS);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

    // Age 0 is MRU. Ways no older than the touched one age by one (saturating),
    // which keeps the ordering strict once every way has been touched after reset.
    logic [AGE_W-1:0] age_q [SETS][WAYS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= '0;
        end else if (touch_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == way_i)
                    age_q[set_i][w] <= '0;
                else if (age_q[set_i][w] <= age_q[set_i][way_i] && age_q[set_i][w] != AGE_MAX)
                    age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
            end
        end
    end

    always_comb begin
        logic             found;
        logic [WAY_W-1:0] oldest;
        found    = 1'b0;
        oldest   = '0;
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                victim_o = WAY_W'(w);
                found    = 1'b1;
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (age_q[set_i][w] > age_q[set_i][oldest])
                oldest = WAY_W'(w);
        end
        if (!found)
            victim_o = oldest;
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative, multi-word-block instruction cache.
//   clk_i, rst_ni      : clock, async active-low reset
//   imem_ren_i         : fetch request
//   imem_addr_i        : fetch byte address, bits [1:0] ignored
//   ihit_o             : imem_load_o valid this cycle (zero-latency hit)
//   imem_load_o        : fetched instruction, 0 when not a hit
//   iren_o, iaddr_o    : memory read request / word address (FILL only)
//   iwait_i, iload_i   : memory not-ready / read data
//   hit_count_o        : number of clock edges that retired a hit
//
// state | meaning
// IDLE  | hit lookup; a miss latches address and victim and starts a fill
// FILL  | fetch the block word by word into the victim way, then back to IDLE
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SETS          = 8,
    parameter int WAYS          = 2,
    parameter int WORDS_PER_BLK = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        imem_ren_i,
    input  logic [31:0] imem_addr_i,
    output logic        ihit_o,
    output logic [31:0] imem_load_o,
    output logic        iren_o,
    output logic [31:0] iaddr_o,
    input  logic        iwait_i,
    input  logic [31:0] iload_i,
    output logic [31:0] hit_count_o
);

    localparam int BOFF_W  = $clog2(WORDS_PER_BLK);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_LSB = 2 + BOFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int WAY_W   = min1_clog2(WAYS);
    localparam int CNT_W   = min1_clog2(WORDS_PER_BLK);

    if (SETS < 2 || WAYS < 1 || WAYS > ICACHE_WAYS_MAX ||
        WORDS_PER_BLK < 1 || WORDS_PER_BLK > ICACHE_WPB_MAX) begin : g_bad_cfg
        $error("icache_assoc: unsupported SETS/WAYS/WORDS_PER_BLK");
    end

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [31:0]      data_q  [SETS][WAYS][WORDS_PER_BLK];

    icache_state_t    state_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [WAY_W-1:0] victim_q;
    logic [CNT_W-1:0] wcnt_q;
    logic [31:0]      hit_count_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [CNT_W-1:0] req_off;
    logic [31:0]      fill_addr;
    logic             unused_addr_bits;

    assign req_idx          = imem_addr_i[2+BOFF_W +: IDX_W];
    assign req_tag          = imem_addr_i[TAG_LSB +: TAG_W];
    assign unused_addr_bits = ^imem_addr_i[1:0];

    if (BOFF_W > 0) begin : g_multi_word
        assign req_off   = imem_addr_i[2 +: BOFF_W];
        assign fill_addr = {miss_tag_q, miss_idx_q, wcnt_q, 2'b00};
    end else begin : g_single_word
        assign req_off   = '0;
        assign fill_addr = {miss_tag_q, miss_idx_q, 2'b00};
    end

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    logic accept, last_word;

    assign ihit_o      = (state_q == IDLE) && imem_ren_i && hit_any;
    assign imem_load_o = ihit_o ? data_q[req_idx][hit_way][req_off] : '0;
    assign iren_o      = (state_q == FILL);
    assign iaddr_o     = (state_q == FILL) ? fill_addr : '0;
    assign hit_count_o = hit_count_q;
    assign accept      = (state_q == FILL) && !iwait_i;
    assign last_word   = accept && (wcnt_q == CNT_W'(WORDS_PER_BLK - 1));

    logic [IDX_W-1:0] lru_set;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] lru_victim;

    // During FILL the tracker must look at the latched set, not the live address.
    assign lru_set = (state_q == FILL) ? miss_idx_q : req_idx;
    assign lru_way = ihit_o ? hit_way : victim_q;

    icache_assoc_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_i    (lru_set),
        .touch_i  (ihit_o | last_word),
        .way_i    (lru_way),
        .valid_i  (valid_q[lru_set]),
        .victim_o (lru_victim)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            victim_q    <= '0;
            wcnt_q      <= '0;
            hit_count_q <= '0;
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ihit_o)
                        hit_count_q <= hit_count_q + 32'd1;
                    else if (imem_ren_i) begin
                        state_q    <= FILL;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        victim_q   <= lru_victim;
                        wcnt_q     <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        // Invalidate before overwriting so a half-written block never hits.
                        if (wcnt_q == '0)
                            valid_q[miss_idx_q][victim_q] <= 1'b0;
                        wcnt_q <= wcnt_q + 1'b1;
                        if (last_word) begin
                            valid_q[miss_idx_q][victim_q] <= 1'b1;
                            wcnt_q  <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            data_q[miss_idx_q][victim_q][wcnt_q] <= iload_i;
            if (last_word)
                tag_q[miss_idx_q][victim_q] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren;
    logic [31:0] addr;
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign iload = mem_word(iaddr);

    icache_assoc #(
        .SETS          (8),
        .WAYS          (2),
        .WORDS_PER_BLK (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .imem_ren_i  (ren),
        .imem_addr_i (addr),
        .ihit_o      (ihit),
        .imem_load_o (load),
        .iren_o      (iren),
        .iaddr_o     (iaddr),
        .iwait_i     (iwait),
        .iload_i     (iload),
        .hit_count_o (hc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cold fill of a 2-word block with iwait low, ending in IDLE with ren dropped.
    task automatic fill_block(input logic [31:0] a);
        logic [31:0] base;
        base  = a & 32'hFFFF_FFF8;
        ren   = 1'b1;
        addr  = a;
        iwait = 1'b0;
        #1;
        chk("fb_miss", 32'(ihit), 32'd0);
        tick;
        for (int i = 0; i < 2; i++) begin
            chk("fb_iren", 32'(iren), 32'd1);
            chk("fb_iaddr", iaddr, base + 32'(4 * i));
            chk("fb_nohit", 32'(ihit), 32'd0);
            tick;
        end
        chk("fb_hit", 32'(ihit), 32'd1);
        chk("fb_load", load, mem_word(a));
        ren = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          words;
        logic        w;
        logic [31:0] prior [8];

        rst_n = 1'b0;
        ren   = 1'b0;
        addr  = 32'h0;
        iwait = 1'b0;
        #12;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_iren", 32'(iren), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_load", load, 32'd0);
        chk("rst_hc", hc, 32'd0);
        rst_n = 1'b1;
        tick;

        // Cold miss on 0x40, then both words hit.
        ren  = 1'b1;
        addr = 32'h40;
        #1;
        chk("t1_miss", 32'(ihit), 32'd0);
        chk("t1_load_miss", load, 32'd0);
        tick;
        chk("t1_iren", 32'(iren), 32'd1);
        chk("t1_iaddr0", iaddr, 32'h40);
        chk("t1_nohit", 32'(ihit), 32'd0);
        tick;
        chk("t1_iaddr1", iaddr, 32'h44);
        tick;
        chk("t1_hit", 32'(ihit), 32'd1);
        chk("t1_load", load, 32'hC0DE_0040);
        chk("t1_hc_fill", hc, 32'd0);
        tick;
        chk("t1_hc1", hc, 32'd1);
        addr = 32'h44;
        #1;
        chk("t1_hit44", 32'(ihit), 32'd1);
        chk("t1_load44", load, 32'hC0DE_0044);
        tick;
        chk("t1_hc2", hc, 32'd2);
        ren = 1'b0;
        tick;
        chk("t1_idle_hc", hc, 32'd2);
        chk("t1_idle_iren", 32'(iren), 32'd0);

        // Same set, three tags: 0x240 is LRU when 0x440 arrives.
        fill_block(32'h240);
        ren  = 1'b1;
        addr = 32'h40;
        #1;
        chk("t2_touch40", 32'(ihit), 32'd1);
        tick;
        ren = 1'b0;
        tick;
        fill_block(32'h440);
        ren  = 1'b1;
        addr = 32'h40;
        #1;
        chk("t2_keep40", 32'(ihit), 32'd1);
        chk("t2_load40", load, 32'hC0DE_0040);
        addr = 32'h440;
        #1;
        chk("t2_hit440", 32'(ihit), 32'd1);
        chk("t2_load440", load, 32'hC0DE_0440);
        addr = 32'h240;
        #1;
        chk("t2_evict240", 32'(ihit), 32'd0);
        ren = 1'b0;
        tick;
        chk("t2_hc", hc, 32'd3);

        // Randomised iwait during fill of 0x88.
        ren   = 1'b1;
        addr  = 32'h88;
        iwait = 1'b0;
        #1;
        chk("t3_miss", 32'(ihit), 32'd0);
        tick;
        words = 0;
        for (int k = 0; k < 64 && words < 2; k++) begin
            iwait = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("t3_iren", 32'(iren), 32'd1);
            chk("t3_iaddr", iaddr, 32'h88 + 32'(4 * words));
            chk("t3_nohit", 32'(ihit), 32'd0);
            w = iwait;
            tick;
            if (!w) words++;
        end
        iwait = 1'b0;
        if (words != 2) begin
            errors++;
            $error("FAIL t3_timeout: observed %0d words expected 2", words);
        end
        chk("t3_hit88", 32'(ihit), 32'd1);
        chk("t3_load88", load, 32'hC0DE_0088);
        addr = 32'h8C;
        #1;
        chk("t3_load8c", load, 32'hC0DE_008C);
        ren = 1'b0;
        tick;

        // Address and request change mid-fill are ignored.
        ren   = 1'b1;
        addr  = 32'h50;
        iwait = 1'b1;
        #1;
        chk("t4_miss", 32'(ihit), 32'd0);
        tick;
        chk("t4_iaddr_a", iaddr, 32'h50);
        addr = 32'h100;
        ren  = 1'b0;
        tick;
        chk("t4_iren_held", 32'(iren), 32'd1);
        chk("t4_iaddr_held", iaddr, 32'h50);
        ren   = 1'b1;
        iwait = 1'b0;
        tick;
        chk("t4_iaddr_b", iaddr, 32'h54);
        tick;
        chk("t4_miss100", 32'(ihit), 32'd0);
        chk("t4_idle", 32'(iren), 32'd0);
        addr = 32'h50;
        #1;
        chk("t4_hit50", 32'(ihit), 32'd1);
        chk("t4_load50", load, 32'hC0DE_0050);
        addr = 32'h54;
        #1;
        chk("t4_load54", load, 32'hC0DE_0054);
        ren = 1'b0;
        tick;
        chk("t4_hc", hc, 32'd3);

        // Reset in the middle of a fill.
        ren  = 1'b1;
        addr = 32'hC8;
        #1;
        tick;
        tick;
        chk("t5_iaddr_mid", iaddr, 32'hCC);
        rst_n = 1'b0;
        #1;
        chk("t5_iren_async", 32'(iren), 32'd0);
        chk("t5_iaddr_async", iaddr, 32'd0);
        chk("t5_hc_async", hc, 32'd0);
        ren = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        prior[0] = 32'h40;  prior[1] = 32'h44;  prior[2] = 32'h440; prior[3] = 32'h88;
        prior[4] = 32'h8C;  prior[5] = 32'h50;  prior[6] = 32'h54;  prior[7] = 32'hC8;
        for (int i = 0; i < 8; i++) begin
            ren  = 1'b1;
            addr = prior[i];
            #1;
            chk("t5_flushed", 32'(ihit), 32'd0);
            ren = 1'b0;
            tick;
        end
        chk("t5_hc", hc, 32'd0);

        // Ten consecutive hit cycles.
        fill_block(32'h40);
        chk("t6_hc_fill", hc, 32'd0);
        ren  = 1'b1;
        addr = 32'h40;
        repeat (10) tick;
        chk("t6_hc10", hc, 32'd10);
        ren = 1'b0;
        tick;
        chk("t6_hc_idle", hc, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
